// File: rtl/bus_arbiter.sv
// bus_arbiter
// Two-master arbiter for a single shared memory bus. Port 0 is instruction
// fetch and port 1 is the memory stage. Port 1 wins ties, but a starvation
// counter hands the bus to port 0 after STARVE_LIMIT consecutive port-1
// completions. m1_lock keeps port 1 on the bus for LDM/STM bursts, and it
// overrides the starvation limit while it is held. When the bus is idle the
// owner is picked combinationally, so arbitration adds no latency.
//
// state | meaning
// IDLE  | no registered owner; owner picked combinationally this cycle
// OWN0  | port 0 holds the bus (wait states, until completion or abort)
// OWN1  | port 1 holds the bus (wait states or locked burst)
//
// Ports
//   clk, Nrst                    clock; synchronous active-high reset
//   m0_* busaddr/rd_req/wr_req/wr_data    port-0 request (in)
//   m0_rw_wait, m0_rd_data                port-0 response (out)
//   m1_* busaddr/rd_req/wr_req/wr_data/lock  port-1 request (in)
//   m1_rw_wait, m1_rd_data                port-1 response (out)
//   busaddr, rd_req, wr_req, wr_data      shared bus request (out)
//   rw_wait, rd_data                      shared bus response (in)
//   grant0, grant1                        effective owner (out)
//   proto_err                             sticky read+write collision flag (out)
module bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        Nrst,
    input  logic [31:0] m0_busaddr,
    input  logic        m0_rd_req,
    input  logic        m0_wr_req,
    input  logic [31:0] m0_wr_data,
    output logic        m0_rw_wait,
    output logic [31:0] m0_rd_data,
    input  logic [31:0] m1_busaddr,
    input  logic        m1_rd_req,
    input  logic        m1_wr_req,
    input  logic [31:0] m1_wr_data,
    input  logic        m1_lock,
    output logic        m1_rw_wait,
    output logic [31:0] m1_rd_data,
    output logic [31:0] busaddr,
    output logic        rd_req,
    output logic        wr_req,
    output logic [31:0] wr_data,
    input  logic        rw_wait,
    input  logic [31:0] rd_data,
    output logic        grant0,
    output logic        grant1,
    output logic        proto_err
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] scnt, scnt_nxt;
    logic          err_q;

    logic m0_req, m1_req;
    logic m0_wr_eff, m1_wr_eff;
    logic own0, own1;
    logic cpl0, cpl1;
    logic err_now;

    assign m0_req = m0_rd_req | m0_wr_req;
    assign m1_req = m1_rd_req | m1_wr_req;

    // A simultaneous read and write is treated as a read.
    assign m0_wr_eff = m0_wr_req & ~m0_rd_req;
    assign m1_wr_eff = m1_wr_req & ~m1_rd_req;

    assign err_now = (m0_rd_req & m0_wr_req) | (m1_rd_req & m1_wr_req);

    // Effective owner. Reset masks every grant combinationally.
    always_comb begin
        own0 = 1'b0;
        own1 = 1'b0;
        if (!Nrst) begin
            case (state)
                OWN0: own0 = 1'b1;
                OWN1: own1 = 1'b1;
                default: begin
                    if (m0_req && m1_req) begin
                        if (scnt == SLIM) own0 = 1'b1;
                        else              own1 = 1'b1;
                    end else if (m0_req) begin
                        own0 = 1'b1;
                    end else if (m1_req) begin
                        own1 = 1'b1;
                    end
                end
            endcase
        end
    end

    assign cpl0 = own0 & m0_req & ~rw_wait;
    assign cpl1 = own1 & m1_req & ~rw_wait;

    // Bus forwarding from the owner; everything zero without one.
    always_comb begin
        busaddr = 32'h0;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        wr_data = 32'h0;
        if (own0) begin
            busaddr = m0_busaddr;
            rd_req  = m0_rd_req;
            wr_req  = m0_wr_eff;
            wr_data = m0_wr_data;
        end else if (own1) begin
            busaddr = m1_busaddr;
            rd_req  = m1_rd_req;
            wr_req  = m1_wr_eff;
            wr_data = m1_wr_data;
        end
    end

    assign m0_rw_wait = own0 ? rw_wait : m0_req;
    assign m1_rw_wait = own1 ? rw_wait : m1_req;
    assign m0_rd_data = rd_data;
    assign m1_rd_data = rd_data;
    assign grant0     = own0;
    assign grant1     = own1;
    assign proto_err  = ~Nrst & (err_q | err_now);

    always_comb begin
        state_nxt = IDLE;
        if (Nrst) begin
            state_nxt = IDLE;
        end else if (own0) begin
            if (m0_req && rw_wait) state_nxt = OWN0;
        end else if (own1) begin
            if (m1_req && rw_wait)     state_nxt = OWN1;
            else if (cpl1 && m1_lock)  state_nxt = OWN1;
        end
    end

    // Starvation counter: counts port-1 completions while port 0 waits.
    always_comb begin
        scnt_nxt = scnt;
        if (Nrst || !m0_req || cpl0) begin
            scnt_nxt = '0;
        end else if (cpl1 && scnt != SLIM) begin
            scnt_nxt = scnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (Nrst) begin
            state <= IDLE;
            scnt  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            scnt  <= scnt_nxt;
            err_q <= err_q | err_now;
        end
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: number of consecutive port-1 transfer completions tolerated while port 0 waits.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port Nrst, input, 1 bit: reset, synchronous and active-high (1 = reset asserted).
REQ-004 Ports m0_busaddr (in, 32), m0_rd_req (in, 1), m0_wr_req (in, 1) and m0_wr_data (in, 32): the port-0 requester, which is instruction fetch.
REQ-005 Ports m0_rw_wait (out, 1) and m0_rd_data (out, 32): the port-0 responses.
REQ-006 Ports m1_busaddr (in, 32), m1_rd_req (in, 1), m1_wr_req (in, 1), m1_wr_data (in, 32) and m1_lock (in, 1): the port-1 requester, which is the memory stage; m1_lock holds the bus for LDM/STM bursts.
REQ-007 Ports m1_rw_wait (out, 1) and m1_rd_data (out, 32): the port-1 responses.
REQ-008 Ports busaddr (out, 32), rd_req (out, 1), wr_req (out, 1) and wr_data (out, 32): the shared bus request.
REQ-009 Ports rw_wait (in, 1) and rd_data (in, 32): the shared bus response.
REQ-010 Ports grant0 (out, 1), grant1 (out, 1) and proto_err (out, 1): status outputs.

Function
REQ-011 A port requests when its rd_req or its wr_req is 1.
REQ-012 If a port drives both rd_req and wr_req in the same cycle, the block SHALL treat it as a read, forward wr_req = 0, and set proto_err, which is sticky until reset.
REQ-013 State SHALL be one of IDLE, OWN0 or OWN1, plus a starvation counter scnt of width clog2(STARVE_LIMIT+1).
REQ-014 Effective owner:
  - OWN0 → port 0; OWN1 → port 1.
  - IDLE → combinational pick in the same cycle, so arbitration adds zero latency.
REQ-015 IDLE pick:
  - only one port requesting → that port;
  - both requesting → port 1, unless scnt == STARVE_LIMIT, in which case port 0;
  - none requesting → no owner.
REQ-016 Owner forwarding:
  - busaddr, rd_req, wr_req and wr_data come from the owner;
  - with no owner, rd_req = wr_req = 0 and busaddr/wr_data = 0.
REQ-017 Owner rw_wait SHALL equal bus rw_wait.
REQ-018 A requesting non-owner SHALL see rw_wait = 1; a non-requesting port SHALL see rw_wait = 0.
REQ-019 rd_data SHALL be broadcast unmodified to m0_rd_data and m1_rd_data.
REQ-020 Completion is a cycle in which the owner requests and bus rw_wait = 0.
REQ-021 Next state:
  - owner requesting and not complete → OWNx, holding the grant through wait states;
  - completion by port 1 with m1_lock = 1 → OWN1;
  - any other completion → IDLE;
  - owner request dropped without completion → IDLE (abort).
REQ-022 The grant SHALL NOT change on any cycle other than a completion or an abort.
REQ-023 grant0/grant1 SHALL be combinational copies of the effective owner and SHALL be mutually exclusive.
REQ-024 scnt update:
  - port-1 completion while port 0 requests → increment, saturating at STARVE_LIMIT;
  - port-0 completion → clear to 0;
  - cycle in which port 0 does not request → clear to 0;
  - otherwise → hold.
REQ-025 m1_lock SHALL override starvation, so port 0 waits until the locked burst ends.
REQ-026 m1_lock asserted while port 1 does not own the bus SHALL have no effect.
REQ-027 Back-to-back transfers by one port SHALL complete one per cycle when bus rw_wait = 0.

Reset
REQ-028 While Nrst = 1, all of the following SHALL hold:
  - state forced to IDLE; scnt = 0; proto_err = 0;
  - rd_req = wr_req = 0; busaddr = wr_data = 0; grant0 = grant1 = 0;
  - each requesting port sees rw_wait = 1.
REQ-029 Reset asserted mid-transfer SHALL abort it without a completion.
REQ-030 The first cycle after reset release SHALL behave as IDLE.

Verification
REQ-031 Only m0 reads addr 0x100, bus rw_wait = 0 → same cycle: busaddr = 0x100, rd_req = 1, grant0 = 1, m0_rw_wait = 0; next state IDLE.
REQ-032 m0 and m1 both request, scnt = 0 → m1 granted; m0_rw_wait = 1. Bus holds rw_wait = 1 for 3 cycles → grant stays on m1 for all 3; m1 completes in cycle 4.
REQ-033 m0 requests continuously; m1 issues 5 back-to-back unlocked reads, STARVE_LIMIT = 4 → m1 completes 4 transfers, m0 then gets 1 transfer, then m1 gets its 5th.
REQ-034 m1_lock = 1 across an 8-word LDM with m0 waiting → m1 owns the bus for all 8 completions regardless of scnt; m0 is granted the cycle after the lock drops with the final completion.
REQ-035 m1 asserts rd_req and wr_req together → rd_req = 1, wr_req = 0, proto_err = 1, held until Nrst.
REQ-036 Nrst = 1 mid-wait during an m1 write → same cycle wr_req = 0; next cycle scnt = 0 and state IDLE; after release an m0 request is granted immediately.
